regfile: RTL and testbench
==========================

Name: regfile

Overview:
- Architectural register file answering the decode stage's two read requests (enable + 5-bit address → 32-bit data).
- Accepts one write per cycle from the write-back stage.
- Also holds the HI/LO register pair used by MFHI/MFLO/MTHI/MTLO.
- Sits between ID (read side) and MEM/WB (write side); it is the responder end of the decode stage's read interface.

Parameters:
- DATA_W, 32, register width (RegBus)
- ADDR_W, 5, register address width (RegAddrBus)
- NUM_REGS, 32, number of GPRs (2**ADDR_W)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low (0 = reset asserted)
- we  in  1  GPR write enable from WB
- waddr  in  ADDR_W  GPR write address
- wdata  in  DATA_W  GPR write data
- re1  in  1  read port 1 enable (ID reg1_read)
- raddr1  in  ADDR_W  read port 1 address
- rdata1  out  DATA_W  read port 1 data
- re2  in  1  read port 2 enable (ID reg2_read)
- raddr2  in  ADDR_W  read port 2 address
- rdata2  out  DATA_W  read port 2 data
- hilo_we  in  1  HI/LO write enable from WB
- hi_i  in  DATA_W  HI write data
- lo_i  in  DATA_W  LO write data
- hi_o  out  DATA_W  current HI
- lo_o  out  DATA_W  current LO

Behaviour:
- Reset (rst=0, async): all GPRs, HI and LO clear to 0 immediately, without waiting for a clock edge. rdata1/rdata2 = 0 while reset is held; hi_o/lo_o = 0.
- GPR write: on a rising edge with rst=1, we=1 and waddr!=0, reg[waddr] <= wdata.
  - A write to r0 is discarded; r0 always reads 0.
  - Writes with we=0 leave all state unchanged.
- Read (combinational, zero latency). For port n:
  - re_n=0 → 0
  - raddr_n=0 → 0
  - re_n=1 and we=1 and waddr==raddr_n (nonzero) → wdata (same-cycle write-through bypass)
  - otherwise → reg[raddr_n]
- Both ports may address the same register; each sees identical data, including the bypass case.
- HI/LO: on a rising edge with rst=1 and hilo_we=1, HI <= hi_i and LO <= lo_i (always written together).
  - hi_o/lo_o also bypass: when hilo_we=1 they show hi_i/lo_i in the same cycle, otherwise the stored values.
- Write and read of different registers in the same cycle: the read returns the old stored value of its own register, unaffected.
- Reset asserted mid-write: reset wins, and the register stays 0 after the edge.
- Reset deasserted: the first edge with rst=1 performs a normal write.
- No X propagation: unused read ports output 0, never stale data.
- Latency: write visible at the read port in the same cycle (bypass) and stored from the next cycle onward.

Decomposition:
- Shared defines package holds:
  - RegBus/RegAddrBus widths
  - ZeroWord
  - NOPRegAddr (5'b0)
  - WriteEnable/WriteDisable
  - ReadEnable/ReadDisable
  - an RstEnable value for the active-low reset (1'b0)
- One sub-module is natural: hilo_reg. It contains the HI/LO pair, its write enable, async reset and bypass, and is instantiated once inside regfile.
- The GPR array and both read muxes stay in regfile.

Test Plan:
- Reset: hold rst=0 and drive re1=re2=1 with raddr1=5, raddr2=31 → rdata1=rdata2=0 and hi_o=lo_o=0. Pulse rst low mid-simulation after writing r5=0x1234 → r5 reads 0 immediately, before the next clock edge.
- Write then read: we=1, waddr=3, wdata=0xDEADBEEF for one edge, then we=0 with raddr1=3, re1=1 → rdata1=0xDEADBEEF. With re1=0 → rdata1=0.
- r0 hardwired: we=1, waddr=0, wdata=0xFFFFFFFF; then raddr1=raddr2=0, re1=re2=1 → both read 0, both before and after the edge.
- Bypass: r7 holds 0x11; in one cycle set we=1, waddr=7, wdata=0x22 and raddr1=raddr2=7 → both ports show 0x22 before the edge and 0x22 after. With raddr2=8 in the same cycle → port 2 reads r8's old value.
- HI/LO: hilo_we=1, hi_i=0xAAAA0000, lo_i=0x0000BBBB → hi_o/lo_o show those values in the same cycle and hold them after hilo_we drops. Asserting rst=0 → both 0.
- Back-to-back writes: write r1=1, r2=2, r1=3 on consecutive edges while reading r1 on port 1 each cycle → observed 1, 1→(bypass)… final r1=3, r2=2. No lost or reordered writes.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths, constant encodings and read-source selection for the register file.
package regfile_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int NumRegs    = 1 << RegAddrBus;

    localparam logic [RegBus-1:0]     ZeroWord   = '0;
    localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic ReadEnable   = 1'b1;
    localparam logic ReadDisable  = 1'b0;
    localparam logic RstEnable    = 1'b0;   // reset is active-low

    // Where a read port takes its data from.
    typedef enum logic [1:0] {
        RD_ZERO   = 2'd0,
        RD_BYPASS = 2'd1,
        RD_STORED = 2'd2
    } rd_src_e;

    // Priority: reset, disabled port and r0 force zero; a same-cycle write
    // to the addressed register is forwarded; otherwise the stored value.
    function automatic rd_src_e rd_select(
        input logic in_reset,
        input logic enabled,
        input logic addr_is_zero,
        input logic write_hit
    );
        rd_src_e src;
        if (in_reset || !enabled || addr_is_zero) begin
            src = RD_ZERO;
        end else if (write_hit) begin
            src = RD_BYPASS;
        end else begin
            src = RD_STORED;
        end
        return src;
    endfunction

endpackage

// File: rtl/regfile_if.sv
// Decode-read / write-back / HI-LO bus between the pipeline and the register file.
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = RegBus,
    parameter int ADDR_W = RegAddrBus
);
    // GPR write side (from WB)
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    // GPR read side (from ID)
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;

    // HI/LO pair
    logic              hilo_we;
    logic [DATA_W-1:0] hi_i;
    logic [DATA_W-1:0] lo_i;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;

    // Pipeline side: issues writes and read requests.
    modport master (
        output we, waddr, wdata,
        output re1, raddr1, re2, raddr2,
        output hilo_we, hi_i, lo_i,
        input  rdata1, rdata2, hi_o, lo_o
    );

    // Register file side: answers the requests.
    modport slave (
        input  we, waddr, wdata,
        input  re1, raddr1, re2, raddr2,
        input  hilo_we, hi_i, lo_i,
        output rdata1, rdata2, hi_o, lo_o
    );

endinterface

// File: rtl/regfile_hilo_reg.sv
// HI/LO register pair: written together, async active-low clear, same-cycle bypass.
module hilo_reg
    import regfile_pkg::*;
#(
    parameter int DATA_W = RegBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] hi_d;
    logic [DATA_W-1:0] lo_d;

    // Next state: load both halves on a write, otherwise hold.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (we_i == WriteEnable) begin
            hi_d = hi_i;
            lo_d = lo_i;
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Outputs: zero during reset, forward a pending write, else stored pair.
    always_comb begin
        hi_o = hi_q;
        lo_o = lo_q;
        if (rst == RstEnable) begin
            hi_o = '0;
            lo_o = '0;
        end else if (we_i == WriteEnable) begin
            hi_o = hi_i;
            lo_o = lo_i;
        end
    end

endmodule

// File: rtl/regfile.sv
// Architectural register file: 2 combinational read ports with write-through
// bypass, 1 write port, r0 hardwired to zero, plus the HI/LO pair.
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RegBus,
    parameter int ADDR_W   = RegAddrBus,
    parameter int NUM_REGS = 2 ** ADDR_W
) (
    input  logic      clk,
    input  logic      rst,
    regfile_if.slave  bus
);

    localparam int NUM_RD = 2;

    logic [DATA_W-1:0] gpr_q [NUM_REGS];
    logic [DATA_W-1:0] gpr_d [NUM_REGS];

    logic              wr_valid;
    logic [DATA_W-1:0] hi_w;
    logic [DATA_W-1:0] lo_w;

    logic [NUM_RD-1:0]             rd_en;
    logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;

    // Writes to r0 are dropped here, so r0 keeps its reset value of zero.
    assign wr_valid = (bus.we == WriteEnable) && (bus.waddr != '0);

    // Next state of the GPR array: at most one register changes per cycle.
    always_comb begin
        gpr_d = gpr_q;
        if (wr_valid) begin
            gpr_d[bus.waddr] = bus.wdata;
        end
    end

    // GPR array, cleared asynchronously so reads are zero as soon as reset asserts.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr_q[i] <= '0;
            end
        end else begin
            gpr_q <= gpr_d;
        end
    end

    assign rd_en[0]   = bus.re1;
    assign rd_addr[0] = bus.raddr1;
    assign rd_en[1]   = bus.re2;
    assign rd_addr[1] = bus.raddr2;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            rd_src_e src_w;

            assign src_w = rd_select(
                rst == RstEnable,
                rd_en[gi] == ReadEnable,
                rd_addr[gi] == '0,
                wr_valid && (bus.waddr == rd_addr[gi])
            );

            // Read mux for this port.
            always_comb begin
                rd_data[gi] = '0;
                case (src_w)
                    RD_BYPASS: rd_data[gi] = bus.wdata;
                    RD_STORED: rd_data[gi] = gpr_q[rd_addr[gi]];
                    default:   rd_data[gi] = '0;
                endcase
            end
        end
    endgenerate

    assign bus.rdata1 = rd_data[0];
    assign bus.rdata2 = rd_data[1];

    hilo_reg #(
        .DATA_W (DATA_W)
    ) u_hilo (
        .clk  (clk),
        .rst  (rst),
        .we_i (bus.hilo_we),
        .hi_i (bus.hi_i),
        .lo_i (bus.lo_i),
        .hi_o (hi_w),
        .lo_o (lo_w)
    );

    assign bus.hi_o = hi_w;
    assign bus.lo_o = lo_w;

endmodule

// File: tb/tb_regfile.sv
// Directed test of regfile: reset, write/read, r0, bypass, HI/LO, back-to-back writes.
module tb_regfile;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    regfile_if rf_if ();

    regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (rf_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        $display("chk %s obs=%h exp=%h", tag, obs, exp);
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Move to 2 time units after the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        rf_if.we      = 1'b0;
        rf_if.waddr   = '0;
        rf_if.wdata   = '0;
        rf_if.re1     = 1'b1;
        rf_if.raddr1  = 5'd5;
        rf_if.re2     = 1'b1;
        rf_if.raddr2  = 5'd31;
        rf_if.hilo_we = 1'b0;
        rf_if.hi_i    = '0;
        rf_if.lo_i    = '0;

        // Reset held: everything reads zero, even with a write aimed at the read address.
        step();
        #1;
        chk("rst_rd1", rf_if.rdata1, 32'h0);
        chk("rst_rd2", rf_if.rdata2, 32'h0);
        chk("rst_hi", rf_if.hi_o, 32'h0);
        chk("rst_lo", rf_if.lo_o, 32'h0);
        rf_if.we = 1'b1; rf_if.waddr = 5'd5; rf_if.wdata = 32'h55;
        rf_if.hilo_we = 1'b1; rf_if.hi_i = 32'h1; rf_if.lo_i = 32'h2;
        #1;
        chk("rst_nobyp", rf_if.rdata1, 32'h0);
        chk("rst_nohibyp", rf_if.hi_o, 32'h0);
        step();
        rf_if.we = 1'b0; rf_if.hilo_we = 1'b0;
        #1;
        chk("rst_midwr", rf_if.rdata1, 32'h0);

        // Release reset mid-cycle; first edge performs a normal write.
        rst = 1'b1;
        rf_if.we = 1'b1; rf_if.waddr = 5'd3; rf_if.wdata = 32'hDEADBEEF;
        step();
        rf_if.we = 1'b0; rf_if.raddr1 = 5'd3; rf_if.re1 = 1'b1;
        #1;
        chk("wr_rd_r3", rf_if.rdata1, 32'hDEADBEEF);
        rf_if.re1 = 1'b0;
        #1;
        chk("re1_off", rf_if.rdata1, 32'h0);
        rf_if.re1 = 1'b1;
        rf_if.raddr1 = 5'd5;
        #1;
        chk("r5_untouched", rf_if.rdata1, 32'h0);

        // r0 is hardwired to zero.
        rf_if.we = 1'b1; rf_if.waddr = 5'd0; rf_if.wdata = 32'hFFFFFFFF;
        rf_if.raddr1 = 5'd0; rf_if.raddr2 = 5'd0;
        #1;
        chk("r0_pre_p1", rf_if.rdata1, 32'h0);
        chk("r0_pre_p2", rf_if.rdata2, 32'h0);
        step();
        rf_if.we = 1'b0;
        #1;
        chk("r0_post_p1", rf_if.rdata1, 32'h0);
        chk("r0_post_p2", rf_if.rdata2, 32'h0);

        // Bypass: r7=0x11, r8=0x88, then overwrite r7 while reading it.
        rf_if.we = 1'b1; rf_if.waddr = 5'd7; rf_if.wdata = 32'h11;
        step();
        rf_if.waddr = 5'd8; rf_if.wdata = 32'h88;
        step();
        rf_if.waddr = 5'd7; rf_if.wdata = 32'h22;
        rf_if.raddr1 = 5'd7; rf_if.raddr2 = 5'd7;
        #1;
        chk("byp_p1", rf_if.rdata1, 32'h22);
        chk("byp_p2", rf_if.rdata2, 32'h22);
        rf_if.raddr2 = 5'd8;
        #1;
        chk("byp_other", rf_if.rdata2, 32'h88);
        step();
        rf_if.we = 1'b0; rf_if.raddr2 = 5'd7;
        #1;
        chk("byp_post_p1", rf_if.rdata1, 32'h22);
        chk("byp_post_p2", rf_if.rdata2, 32'h22);

        // HI/LO write with same-cycle visibility, then hold.
        rf_if.hilo_we = 1'b1; rf_if.hi_i = 32'hAAAA0000; rf_if.lo_i = 32'h0000BBBB;
        #1;
        chk("hi_byp", rf_if.hi_o, 32'hAAAA0000);
        chk("lo_byp", rf_if.lo_o, 32'h0000BBBB);
        step();
        rf_if.hilo_we = 1'b0; rf_if.hi_i = 32'h0; rf_if.lo_i = 32'h0;
        #1;
        chk("hi_hold", rf_if.hi_o, 32'hAAAA0000);
        chk("lo_hold", rf_if.lo_o, 32'h0000BBBB);

        // Back-to-back writes r1=1, r2=2, r1=3 while reading r1.
        rf_if.raddr1 = 5'd1;
        rf_if.we = 1'b1; rf_if.waddr = 5'd1; rf_if.wdata = 32'd1;
        #1;
        chk("b2b_c0", rf_if.rdata1, 32'd1);
        step();
        rf_if.waddr = 5'd2; rf_if.wdata = 32'd2;
        #1;
        chk("b2b_c1", rf_if.rdata1, 32'd1);
        step();
        rf_if.waddr = 5'd1; rf_if.wdata = 32'd3;
        #1;
        chk("b2b_c2", rf_if.rdata1, 32'd3);
        step();
        rf_if.we = 1'b0; rf_if.raddr2 = 5'd2;
        #1;
        chk("b2b_r1", rf_if.rdata1, 32'd3);
        chk("b2b_r2", rf_if.rdata2, 32'd2);

        // Async reset mid-cycle after r5=0x1234: zero before any edge.
        rf_if.we = 1'b1; rf_if.waddr = 5'd5; rf_if.wdata = 32'h1234;
        step();
        rf_if.we = 1'b0; rf_if.raddr1 = 5'd5;
        #1;
        chk("r5_written", rf_if.rdata1, 32'h1234);
        rst = 1'b0;
        #1;
        chk("async_r5", rf_if.rdata1, 32'h0);
        chk("async_hi", rf_if.hi_o, 32'h0);
        chk("async_lo", rf_if.lo_o, 32'h0);
        rst = 1'b1;
        #1;
        chk("async_r5_cleared", rf_if.rdata1, 32'h0);
        chk("async_hi_cleared", rf_if.hi_o, 32'h0);

        // Reset asserted across a write edge: reset wins.
        rst = 1'b0;
        rf_if.we = 1'b1; rf_if.waddr = 5'd9; rf_if.wdata = 32'h99;
        step();
        rst = 1'b1; rf_if.we = 1'b0; rf_if.raddr2 = 5'd9;
        #1;
        chk("rst_wins_r9", rf_if.rdata2, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
